// File: rtl/map_sunsoft_gen.sv
// Sunsoft-4-class NES mapper core: banked PRG/CHR, CHR-ROM nametables and a CPU-cycle IRQ counter.
// Runs on the fast system clock; CPU writes commit on the falling edge of the synchronised m2.
module map_sunsoft_gen #(
   parameter int unsigned CHR_WIN = 4,
   parameter int unsigned CHR_AW  = 18,
   parameter int unsigned PRG_AW  = 18,
   parameter bit          NT_ROM  = 1'b1,
   parameter bit          IRQ_EN  = 1'b1,
   parameter logic [7:0]  MAP_IDX = 8'd68
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m2,
   input  logic [14:0]       cpu_addr,
   input  logic [7:0]        cpu_dat,
   input  logic              cpu_rw,
   input  logic              rom_sel_n,
   input  logic [13:0]       ppu_addr,
   output logic [PRG_AW-1:0] prg_addr,
   output logic [CHR_AW-1:0] chr_addr,
   output logic              ciram_a10,
   output logic              ciram_ce,
   output logic              irq_n,
   input  logic              ss_act,
   input  logic              ss_we,
   input  logic [7:0]        ss_addr,
   output logic [7:0]        ss_rdat
);

   localparam int unsigned CW      = CHR_AW - 10;
   localparam int unsigned NW      = CHR_AW - 11;
   localparam int unsigned PW      = PRG_AW - 14;
   localparam int unsigned IW      = (CHR_WIN == 8) ? 3 : 2;
   localparam logic [7:0]  NUM_WIN = 8'(CHR_WIN);

   logic          m2_s1_q, m2_s2_q, m2_s3_q, m2_fall;
   logic [14:0]   addr_q;
   logic [7:0]    dat_q;
   logic          rw_q, rom_sel_n_q, cpu_wr;
   logic [CW-1:0] chr_q [CHR_WIN];
   logic [CW-1:0] chr_d [CHR_WIN];
   logic [NW-1:0] nt_q [2];
   logic [NW-1:0] nt_d [2];
   logic [PW-1:0] prg_q, prg_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          cnt_en_q, cnt_en_d, irq_en_q, irq_en_d, pend_q, pend_d;
   logic [IW-1:0] ridx;
   logic          nt_area;
   logic          unused_bits;

   assign m2_fall     = m2_s3_q & ~m2_s2_q;
   assign cpu_wr      = ~rom_sel_n_q & ~rw_q;
   assign unused_bits = ^{addr_q[11:2], dat_q};

   // Bus is captured continuously while m2 is high so it is stable when the fall commits it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2_s1_q     <= 1'b0;
         m2_s2_q     <= 1'b0;
         m2_s3_q     <= 1'b0;
         addr_q      <= '0;
         dat_q       <= '0;
         rw_q        <= 1'b0;
         rom_sel_n_q <= 1'b0;
      end else begin
         m2_s1_q <= m2;
         m2_s2_q <= m2_s1_q;
         m2_s3_q <= m2_s2_q;
         if (m2_s2_q) begin
            addr_q      <= cpu_addr;
            dat_q       <= cpu_dat;
            rw_q        <= cpu_rw;
            rom_sel_n_q <= rom_sel_n;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(CHR_WIN); i++) chr_q[i] <= '0;
         nt_q[0]  <= '0;
         nt_q[1]  <= '0;
         prg_q    <= '0;
         ctrl_q   <= '0;
         cnt_q    <= '0;
         cnt_en_q <= 1'b0;
         irq_en_q <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         chr_q    <= chr_d;
         nt_q     <= nt_d;
         prg_q    <= prg_d;
         ctrl_q   <= ctrl_d;
         cnt_q    <= cnt_d;
         cnt_en_q <= cnt_en_d;
         irq_en_q <= irq_en_d;
         pend_q   <= pend_d;
      end
   end

   // Decrement first, then let a same-edge register write override the affected field.
   always_comb begin
      chr_d    = chr_q;
      nt_d     = nt_q;
      prg_d    = prg_q;
      ctrl_d   = ctrl_q;
      cnt_d    = cnt_q;
      cnt_en_d = cnt_en_q;
      irq_en_d = irq_en_q;
      pend_d   = pend_q;
      if (m2_fall) begin
         if (!ss_act && cnt_en_q) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'h0000 && irq_en_q) pend_d = 1'b1;
         end
         if (ss_act) begin
            if (ss_we) begin
               if (ss_addr < NUM_WIN) begin
                  chr_d[ss_addr[IW-1:0]] = dat_q[CW-1:0];
               end else begin
                  case (ss_addr)
                     8'd8:  nt_d[0]   = dat_q[NW-1:0];
                     8'd9:  nt_d[1]   = dat_q[NW-1:0];
                     8'd10: prg_d     = dat_q[PW-1:0];
                     8'd11: ctrl_d    = {NT_ROM & dat_q[1], dat_q[0]};
                     8'd12: cnt_d[7:0]  = dat_q;
                     8'd13: cnt_d[15:8] = dat_q;
                     8'd14: begin
                        pend_d   = dat_q[2];
                        cnt_en_d = dat_q[1];
                        irq_en_d = dat_q[0];
                     end
                     default: ;
                  endcase
               end
            end
         end else if (cpu_wr) begin
            case (addr_q[14:12])
               3'd0, 3'd1, 3'd2, 3'd3: chr_d[addr_q[13 -: IW]] = dat_q[CW-1:0];
               3'd4: nt_d[0] = dat_q[NW-1:0];
               3'd5: nt_d[1] = dat_q[NW-1:0];
               3'd6: begin
                  case (addr_q[1:0])
                     2'd0: ctrl_d      = {NT_ROM & dat_q[4], dat_q[0]};
                     2'd1: cnt_d[7:0]  = dat_q;
                     2'd2: cnt_d[15:8] = dat_q;
                     default: begin
                        cnt_en_d = dat_q[1];
                        irq_en_d = dat_q[0];
                        pend_d   = 1'b0;
                     end
                  endcase
               end
               default: prg_d = dat_q[PW-1:0];
            endcase
         end
      end
      if (!IRQ_EN) begin
         cnt_d    = '0;
         cnt_en_d = 1'b0;
         irq_en_d = 1'b0;
         pend_d   = 1'b0;
      end
   end

   assign prg_addr  = {cpu_addr[14] ? {PW{1'b1}} : prg_q, cpu_addr[13:0]};
   assign nt_area   = ppu_addr[13] & ~ppu_addr[12] & ctrl_q[1];
   assign ciram_a10 = ctrl_q[0] ? ppu_addr[11] : ppu_addr[10];
   assign ciram_ce  = nt_area | ~ppu_addr[13];
   assign ridx      = ppu_addr[12 -: IW];
   assign irq_n     = ~pend_q;

   always_comb begin
      if (nt_area) chr_addr = {1'b1, nt_q[ciram_a10], ppu_addr[9:0]};
      else if (CHR_WIN == 8) chr_addr = {chr_q[ridx], ppu_addr[9:0]};
      else chr_addr = {chr_q[ridx][CW-2:0], ppu_addr[10:0]};
   end

   always_comb begin
      ss_rdat = 8'hFF;
      if (ss_addr < NUM_WIN) begin
         ss_rdat = '0;
         ss_rdat[CW-1:0] = chr_q[ss_addr[IW-1:0]];
      end else begin
         case (ss_addr)
            8'd8:   begin ss_rdat = '0; ss_rdat[NW-1:0] = nt_q[0]; end
            8'd9:   begin ss_rdat = '0; ss_rdat[NW-1:0] = nt_q[1]; end
            8'd10:  begin ss_rdat = '0; ss_rdat[PW-1:0] = prg_q; end
            8'd11:  ss_rdat = {6'd0, ctrl_q};
            8'd12:  ss_rdat = cnt_q[7:0];
            8'd13:  ss_rdat = cnt_q[15:8];
            8'd14:  ss_rdat = {5'd0, pend_q, cnt_en_q, irq_en_q};
            8'd127: ss_rdat = MAP_IDX;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_map_sunsoft_gen.sv
// Bench for map_sunsoft_gen: directed scenarios plus random bus traffic on a 2KB-window and a
// 1KB-window instance, both compared against an arithmetic model of the mapper registers.
module tb_map_sunsoft_gen;

   logic        clk = 1'b0, rst_n = 1'b0, m2 = 1'b0;
   logic [14:0] cpu_addr = '0;
   logic [7:0]  cpu_dat = '0;
   logic        cpu_rw = 1'b1, rom_sel_n = 1'b1;
   logic [13:0] ppu_addr = '0;
   logic        ss_act = 1'b0, ss_we = 1'b0;
   logic [7:0]  ss_addr = '0;
   logic [17:0] prg4, chr4, prg8, chr8;
   logic        a10_4, ce4, irq4, a10_8, ce8, irq8;
   logic [7:0]  ss4, ss8;

   int n_tests = 0, n_fail = 0;
   int m_chr4 [4];
   int m_chr8 [8];
   int m_nt [2];
   int m_prg, m_ctrl, m_cnt, m_cnt_en, m_irq_en, m_pend;

   always #5 clk = ~clk;

   map_sunsoft_gen #(.CHR_WIN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
      .cpu_rw(cpu_rw), .rom_sel_n(rom_sel_n), .ppu_addr(ppu_addr), .prg_addr(prg4),
      .chr_addr(chr4), .ciram_a10(a10_4), .ciram_ce(ce4), .irq_n(irq4), .ss_act(ss_act),
      .ss_we(ss_we), .ss_addr(ss_addr), .ss_rdat(ss4)
   );

   map_sunsoft_gen #(.CHR_WIN(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
      .cpu_rw(cpu_rw), .rom_sel_n(rom_sel_n), .ppu_addr(ppu_addr), .prg_addr(prg8),
      .chr_addr(chr8), .ciram_a10(a10_8), .ciram_ce(ce8), .irq_n(irq8), .ss_act(ss_act),
      .ss_we(ss_we), .ss_addr(ss_addr), .ss_rdat(ss8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_chr8[i] = 0;
      for (int i = 0; i < 4; i++) m_chr4[i] = 0;
      m_nt[0] = 0; m_nt[1] = 0;
      m_prg = 0; m_ctrl = 0; m_cnt = 0; m_cnt_en = 0; m_irq_en = 0; m_pend = 0;
   endtask

   // One m2 period of bus activity as seen by the mapper registers.
   task automatic model_step(input int a, input int d, input bit rw, input bit sa, input bit sw,
                             input int sad);
      int r;
      if (!sa) begin
         if (m_cnt_en != 0) begin
            if (m_cnt == 0) begin
               m_cnt = 65535;
               if (m_irq_en != 0) m_pend = 1;
            end else m_cnt = m_cnt - 1;
         end
         if (a >= 'h8000 && !rw) begin
            r = (a >> 12) & 7;
            if (r < 4) begin
               m_chr4[r] = d;
               m_chr8[r * 2 + ((a >> 11) & 1)] = d;
            end else if (r == 4) m_nt[0] = d % 128;
            else if (r == 5) m_nt[1] = d % 128;
            else if (r == 7) m_prg = d % 16;
            else begin
               case (a % 4)
                  0: m_ctrl = ((d >> 4) & 1) * 2 + (d & 1);
                  1: m_cnt = (m_cnt / 256) * 256 + d;
                  2: m_cnt = d * 256 + m_cnt % 256;
                  default: begin
                     m_cnt_en = (d >> 1) & 1;
                     m_irq_en = d & 1;
                     m_pend = 0;
                  end
               endcase
            end
         end
      end else if (sw) begin
         if (sad < 8) begin
            m_chr8[sad] = d;
            if (sad < 4) m_chr4[sad] = d;
         end else begin
            case (sad)
               8:  m_nt[0] = d % 128;
               9:  m_nt[1] = d % 128;
               10: m_prg = d % 16;
               11: m_ctrl = d % 4;
               12: m_cnt = (m_cnt / 256) * 256 + d;
               13: m_cnt = d * 256 + m_cnt % 256;
               14: begin
                  m_pend = (d >> 2) & 1;
                  m_cnt_en = (d >> 1) & 1;
                  m_irq_en = d & 1;
               end
               default: ;
            endcase
         end
      end
   endtask

   function automatic int exp_prg(input int ca);
      return (((ca >> 14) & 1) != 0 ? 15 : m_prg) * 16384 + ca % 16384;
   endfunction

   function automatic int exp_a10(input int p);
      return (m_ctrl % 2 == 1) ? (p >> 11) & 1 : (p >> 10) & 1;
   endfunction

   function automatic bit in_nt(input int p);
      return ((p >> 12) & 3) == 2 && (m_ctrl / 2) == 1;
   endfunction

   function automatic int exp_ce(input int p);
      return (in_nt(p) || p < 'h2000) ? 1 : 0;
   endfunction

   function automatic int exp_chr(input int p, input bit win8);
      if (in_nt(p)) return 131072 + m_nt[exp_a10(p)] * 1024 + p % 1024;
      if (win8) return m_chr8[(p >> 10) & 7] * 1024 + p % 1024;
      return (m_chr4[(p >> 11) & 3] % 128) * 2048 + p % 2048;
   endfunction

   function automatic int exp_ss(input int idx, input bit win8);
      if (win8 && idx < 8) return m_chr8[idx];
      if (!win8 && idx < 4) return m_chr4[idx];
      case (idx)
         8:   return m_nt[0];
         9:   return m_nt[1];
         10:  return m_prg;
         11:  return m_ctrl;
         12:  return m_cnt % 256;
         13:  return m_cnt / 256;
         14:  return m_pend * 4 + m_cnt_en * 2 + m_irq_en;
         127: return 68;
         default: return 255;
      endcase
   endfunction

   task automatic bus_cycle(input int a, input int d, input bit rw, input bit sa, input bit sw,
                            input int sad);
      @(negedge clk);
      cpu_addr  = a[14:0];
      rom_sel_n = (a < 'h8000);
      cpu_dat   = d[7:0];
      cpu_rw    = rw;
      ss_act    = sa;
      ss_we     = sw;
      ss_addr   = sad[7:0];
      m2        = 1'b1;
      repeat (6) @(negedge clk);
      m2 = 1'b0;
      repeat (6) @(negedge clk);
      ss_act = 1'b0; ss_we = 1'b0; cpu_rw = 1'b1; rom_sel_n = 1'b1;
      model_step(a, d, rw, sa, sw, sad);
   endtask

   task automatic wr(input int a, input int d);
      bus_cycle(a, d, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic idle();
      bus_cycle(0, 0, 1'b1, 1'b0, 1'b0, 0);
   endtask

   task automatic probe(input int ca, input int pa, input int sa);
      cpu_addr = ca[14:0];
      ppu_addr = pa[13:0];
      ss_addr  = sa[7:0];
      #1;
      check("prg_addr", prg4, exp_prg(ca));
      check("prg_addr8", prg8, exp_prg(ca));
      check("chr_addr4", chr4, exp_chr(pa, 1'b0));
      check("chr_addr8", chr8, exp_chr(pa, 1'b1));
      check("ciram_a10", a10_4, exp_a10(pa));
      check("ciram_ce", ce4, exp_ce(pa));
      check("irq_n", irq4, (m_pend == 0) ? 1 : 0);
      check("irq_n8", irq8, (m_pend == 0) ? 1 : 0);
      check("ss_rdat4", ss4, exp_ss(sa, 1'b0));
      check("ss_rdat8", ss8, exp_ss(sa, 1'b1));
   endtask

   initial begin
      int op, a, d, sad;
      model_reset();
      repeat (3) @(negedge clk);
      probe('h0123, 'h2400, 14);
      check("rst_prg", prg4, 18'h00123);
      check("rst_a10", a10_4, 1);
      check("rst_irq", irq4, 1);
      rst_n = 1'b1;

      wr('hF000, 'h05);
      probe('h0123, 0, 10);
      check("prg_8123", prg4, 18'h14123);
      probe('h4000, 0, 10);
      check("prg_c000", prg4, 18'h3C000);

      wr('h9000, 'h03);
      probe(0, 'h0C00, 1);
      check("chr4_0c00", chr4, 18'h01C00);
      wr('h8800, 'h2A);
      probe(0, 'h0400, 1);
      check("chr8_0400", chr8, 18'h0A800);

      wr('hE000, 'h11);
      wr('hC000, 'h45);
      probe(0, 'h2000, 8);
      check("nt_ce", ce4, 1);
      check("nt_chr", chr4, 18'h31400);
      wr('hE000, 'h10);
      probe(0, 'h2400, 11);
      check("nt_a10", a10_4, 1);

      wr('hE001, 2);
      wr('hE002, 0);
      wr('hE003, 3);
      for (int i = 1; i <= 3; i++) begin
         idle();
         probe(0, 0, 12);
         check("irq_wait", irq4, (i == 3) ? 0 : 1);
      end
      probe(0, 0, 14);
      check("irq_ss14", ss4, 8'h07);
      wr('hE003, 3);
      probe(0, 0, 13);
      check("irq_ack", irq4, 1);
      check("irq_restart_hi", ss4, 8'hFF);

      wr('hE003, 0);
      wr('hE001, 0);
      wr('hE002, 1);
      wr('hE003, 2);
      wr('hE001, 'h80);
      probe(0, 0, 12);
      check("coll_lo", ss4, 8'h80);
      probe(0, 0, 13);
      check("coll_hi", ss4, 8'h00);

      wr('hE003, 0);
      wr('hE001, 0);
      wr('hE002, 0);
      wr('hE003, 3);
      wr('hE003, 3);
      probe(0, 0, 13);
      check("wrap_clr_irq", irq4, 1);
      check("wrap_hi", ss4, 8'hFF);

      bus_cycle(0, 'h0C, 1'b1, 1'b1, 1'b1, 10);
      probe(0, 0, 10);
      check("ss_prg", ss4, 8'h0C);
      bus_cycle('hF000, 'h05, 1'b0, 1'b1, 1'b0, 10);
      probe(0, 0, 10);
      check("ss_block_cpu", prg4, 18'h30000);
      probe(0, 0, 12);
      check("ss_freeze", ss4, 8'hFF);
      probe(0, 0, 127);
      check("ss_map_idx", ss4, 8'd68);
      probe(0, 0, 200);
      check("ss_unmapped", ss4, 8'hFF);

      for (int it = 0; it < 400; it++) begin
         op = $urandom_range(0, 9);
         d  = $urandom_range(0, 255);
         case (op)
            0, 1: begin
               a = 'hE000 + $urandom_range(0, 3);
               if (a == 'hE002) d = $urandom_range(0, 1);
               wr(a, d);
            end
            2, 3, 4: wr('h8000 + $urandom_range(0, 'h7FFF), d);
            5: bus_cycle('h8000 + $urandom_range(0, 'h7FFF), d, 1'b1, 1'b0, 1'b0, 0);
            6: begin
               sad = $urandom_range(0, 15);
               if (sad == 15) sad = 127;
               bus_cycle($urandom_range(0, 'hFFFF), d, 1'b1, 1'b1, 1'b1, sad);
            end
            7: bus_cycle('h8000 + $urandom_range(0, 'h7FFF), d, 1'b0, 1'b1, 1'b0, 0);
            default: idle();
         endcase
         sad = $urandom_range(0, 20);
         if (sad > 16) sad = $urandom_range(0, 255);
         probe($urandom_range(0, 'h7FFF), $urandom_range(0, 'h3FFF), sad);
      end

      // Reset asserted while a CPU write is in flight.
      wr('hF000, 9);
      bus_cycle(0, 7, 1'b1, 1'b1, 1'b1, 14);
      probe(0, 0, 10);
      check("pre_rst_irq", irq4, 0);
      @(negedge clk);
      cpu_addr = 15'h7000; rom_sel_n = 1'b0; cpu_rw = 1'b0; cpu_dat = 8'h07; m2 = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_irq", irq4, 1);
      check("rst_mid_prg", ss4, 8'h00);
      m2 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (8) @(negedge clk);
      rom_sel_n = 1'b1; cpu_rw = 1'b1;
      probe(0, 0, 10);
      check("rst_discard", prg4, 18'h00000);
      wr('hF000, 7);
      probe(0, 0, 10);
      check("post_rst_wr", ss4, 8'h07);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
